// File: rtl/pc_ctrl_pkg.sv
// Shared types and defaults for the PC fetch/redirect sequencer.
// Imported by pc_sequencer and pc_next_mux.
package pc_ctrl_pkg;

  localparam int              PC_DATA_W    = 16;
  localparam int              PC_JIMM_W    = 13;
  localparam logic [15:0]     PC_RESET_VEC = 16'h0000;
  localparam int              PC_INC_DEF   = 2;

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_FETCH = 3'd1,
    S_INCR  = 3'd2,
    S_EXEC  = 3'd3,
    S_HALT  = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    SEL_NONE = 3'd0,
    SEL_RST  = 3'd1,
    SEL_INC  = 3'd2,
    SEL_JUMP = 3'd3,
    SEL_BR   = 3'd4
  } sel_e;

endpackage

// File: rtl/pc_next_mux.sv
// Next-PC selection: reset vector, increment, jump or branch.
// Also produces the PC register write enable.
module pc_next_mux
  import pc_ctrl_pkg::*;
#(
  parameter int                DATA_W    = PC_DATA_W,
  parameter int                JIMM_W    = PC_JIMM_W,
  parameter logic [DATA_W-1:0] RESET_VEC = PC_RESET_VEC,
  parameter int                PC_INC    = PC_INC_DEF
) (
  input  state_e                     state,
  input  logic                       stall,
  input  logic                       instr_done,
  input  logic                       halt,
  input  logic                       jump_en,
  input  logic                       branch_taken,
  input  logic [DATA_W-1:0]          pc_in,
  input  logic [DATA_W-JIMM_W-1:0]   pc_top,
  input  logic [JIMM_W-1:0]          jump_imm,
  input  logic [DATA_W-1:0]          branch_target,
  output logic [DATA_W-1:0]          pc_next,
  output logic                       pc_write
);

  sel_e sel;

  // Halt beats jump beats branch; plain completion keeps the
  // already-incremented PC.
  always_comb begin
    sel = SEL_NONE;
    if (!stall) begin
      unique case (state)
        S_BOOT: sel = SEL_RST;
        S_INCR: sel = SEL_INC;
        S_EXEC: begin
          if (instr_done && !halt) begin
            if (jump_en)           sel = SEL_JUMP;
            else if (branch_taken) sel = SEL_BR;
          end
        end
        default: sel = SEL_NONE;
      endcase
    end
  end

  always_comb begin
    pc_write = (sel != SEL_NONE);
    unique case (sel)
      SEL_INC:  pc_next = pc_in + DATA_W'(PC_INC);
      SEL_JUMP: pc_next = {pc_top, jump_imm};
      SEL_BR:   pc_next = branch_target;
      default:  pc_next = RESET_VEC;
    endcase
  end

endmodule

// File: rtl/pc_sequencer.sv
// Multi-cycle fetch/redirect controller for the program counter.
// Boot, fetch, increment, execute and halt sequencing plus the IR latch.
module pc_sequencer
  import pc_ctrl_pkg::*;
#(
  parameter int                DATA_W    = PC_DATA_W,
  parameter logic [DATA_W-1:0] RESET_VEC = PC_RESET_VEC,
  parameter int                PC_INC    = PC_INC_DEF,
  parameter int                JIMM_W    = PC_JIMM_W
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic [DATA_W-1:0]        PCIn,
  input  logic [DATA_W-JIMM_W-1:0] PCTop,
  output logic [DATA_W-1:0]        PCNext,
  output logic                     PCWrite,
  output logic                     MemReq,
  output logic [DATA_W-1:0]        MemAddr,
  input  logic                     MemReady,
  input  logic [DATA_W-1:0]        MemData,
  output logic [DATA_W-1:0]        IR,
  output logic                     IRValid,
  input  logic                     InstrDone,
  input  logic                     BranchTaken,
  input  logic [DATA_W-1:0]        BranchTarget,
  input  logic                     JumpEn,
  input  logic [JIMM_W-1:0]        JumpImm,
  input  logic                     Halt,
  input  logic                     Stall,
  output logic                     Halted
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] ir_q, ir_d;
  logic              mem_req;

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_q <= S_BOOT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    mem_req = 1'b0;
    if (!Stall) begin
      unique case (state_q)
        S_BOOT: state_d = S_FETCH;
        S_FETCH: begin
          mem_req = 1'b1;
          if (MemReady) begin
            ir_d    = MemData;
            state_d = S_INCR;
          end
        end
        S_INCR: state_d = S_EXEC;
        S_EXEC: begin
          if (InstrDone) state_d = Halt ? S_HALT : S_FETCH;
        end
        S_HALT:  state_d = S_HALT;
        default: state_d = S_BOOT;
      endcase
    end
  end

  pc_next_mux #(
    .DATA_W    (DATA_W),
    .JIMM_W    (JIMM_W),
    .RESET_VEC (RESET_VEC),
    .PC_INC    (PC_INC)
  ) u_next (
    .state         (state_q),
    .stall         (Stall),
    .instr_done    (InstrDone),
    .halt          (Halt),
    .jump_en       (JumpEn),
    .branch_taken  (BranchTaken),
    .pc_in         (PCIn),
    .pc_top        (PCTop),
    .jump_imm      (JumpImm),
    .branch_target (BranchTarget),
    .pc_next       (PCNext),
    .pc_write      (PCWrite)
  );

  assign MemReq  = mem_req;
  assign MemAddr = PCIn;
  assign IR      = ir_q;
  assign IRValid = (state_q == S_EXEC);
  assign Halted  = (state_q == S_HALT);

endmodule
